key_debouncer: RTL and testbench

Conditions one raw push-button input for the counter/display labs. It synchronizes the asynchronous key to clk and filters mechanical bounce with a stable-time counter. It then produces a clean level plus single-cycle press and release strobes. The strobes feed the count_enable and clear inputs of the downstream flex_counter-based counter, so that counter runs on the system clock and is never clocked directly by a key.

---
 rtl/key_debouncer.sv | 194 +++++++++++++++++++
 tb/tb_key_debouncer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// Push-button conditioner: two-flop synchronizer, stable-time debounce FSM,
// and registered level/press/release strobes. Optional auto-repeat under KEY_REPEAT_EN.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_BITS        = 20,
  parameter int ACTIVE_LOW_KEY  = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic                REL_PIN  = (ACTIVE_LOW_KEY != 0);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  // Illegal configurations stop elaboration instead of building a broken filter.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_BITS) - 1) begin : g_bad_debounce
    $error("key_debouncer: DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("key_debouncer: REPEAT_PERIOD must be 1..REPEAT_DELAY");
  end

  logic                sync1_q, sync2_q;
  logic                p;
  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                press_evt_d, rel_evt_d;
  logic                press_strobe_d;
  logic                press_evt_q, rel_evt_q;
  logic                key_level_q, press_pulse_q, release_pulse_q, busy_q;

  // Stage 0: synchronizer, reset to the released pin level so p starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= REL_PIN;
      sync2_q <= REL_PIN;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign p = (ACTIVE_LOW_KEY != 0) ? ~sync2_q : sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_evt_d = 1'b0;
    rel_evt_d   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (p) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_BITS'(1);
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          press_evt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_BITS'(1);
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          rel_evt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int               RPT_W      = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_arm_q, rpt_arm_d;
  logic             rpt_fire;

  // Only a qualified press arms repeats; a release glitch back into PRESSED stays disarmed.
  always_comb begin
    rpt_d     = rpt_q;
    rpt_arm_d = rpt_arm_q;
    rpt_fire  = 1'b0;
    if (press_evt_d) begin
      rpt_d     = '0;
      rpt_arm_d = 1'b1;
    end else if (state_q == PRESSED && state_d == PRESSED) begin
      if (rpt_arm_q) begin
        if (rpt_q == RPT_LAST) begin
          rpt_fire = 1'b1;
          rpt_d    = RPT_RELOAD;
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
      end
    end else if (state_d != PRESSED) begin
      rpt_d     = '0;
      rpt_arm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q     <= '0;
      rpt_arm_q <= 1'b0;
    end else begin
      rpt_q     <= rpt_d;
      rpt_arm_q <= rpt_arm_d;
    end
  end

  assign press_strobe_d = press_evt_d | rpt_fire;
`else
  assign press_strobe_d = press_evt_d;
`endif

  // Stage 1: FSM state, stable-time counter and strobe events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      press_evt_q <= 1'b0;
      rel_evt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_evt_q <= press_strobe_d;
      rel_evt_q   <= rel_evt_d;
    end
  end

  // Stage 2: registered outputs decoded from the settled state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      key_level_q     <= (state_q == PRESSED) || (state_q == RELEASE_WAIT);
      busy_q          <= (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);
      press_pulse_q   <= press_evt_q;
      release_pulse_q <= rel_evt_q;
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with defaults (DEBOUNCE_CYCLES=4, active-low key).
module tb_key_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic key_level, press_pulse, release_pulse, busy;

  int checks   = 0;
  int failures = 0;
  int n_press  = 0;
  int n_rel    = 0;
  logic [3:0] dn_cnt = 4'h0;

  key_debouncer dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pressed;
    int   hold;
    int   exp_press;
    int   exp_rel;
    logic exp_level;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse monitor plus a downstream 4-bit counter enabled by press strobes
  always @(negedge clk) begin
    if (!rst) begin
      checks <= checks + 1;
      if (press_pulse && release_pulse) begin
        failures <= failures + 1;
        $display("FAIL strobe_overlap: press=1 release=1 expected not both at %0t", $time);
      end
      if (press_pulse) begin
        n_press <= n_press + 1;
        dn_cnt  <= dn_cnt + 4'h1;
      end
      if (release_pulse) n_rel <= n_rel + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_key(input logic pressed);
    key_in = ~pressed;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int p0, r0;

    tbl[0] = '{1'b1, 3,  0, 0, 1'b0};
    tbl[1] = '{1'b0, 2,  0, 0, 1'b0};
    tbl[2] = '{1'b1, 10, 1, 0, 1'b1};
    tbl[3] = '{1'b0, 2,  0, 0, 1'b1};
    tbl[4] = '{1'b1, 10, 0, 0, 1'b1};
    tbl[5] = '{1'b0, 4,  0, 0, 1'b1};
    tbl[6] = '{1'b1, 10, 1, 1, 1'b1};
    tbl[7] = '{1'b0, 3,  0, 0, 1'b1};
    tbl[8] = '{1'b1, 8,  0, 0, 1'b1};
    tbl[9] = '{1'b0, 10, 0, 1, 1'b0};

    rst    = 1'b1;
    key_in = 1'b1;
    idle(3);
    check("reset_level",   int'(key_level),     0);
    check("reset_press",   int'(press_pulse),   0);
    check("reset_release", int'(release_pulse), 0);
    check("reset_busy",    int'(busy),          0);
    rst = 1'b0;
    idle(3);

    // Clean press: strobe and level arrive after edge 6, busy after edges 3..5
    set_key(1'b1);
    for (int e = 0; e < 10; e++) begin
      step();
      check($sformatf("press_pulse_e%0d", e), int'(press_pulse), int'(e == 6));
      check($sformatf("press_level_e%0d", e), int'(key_level),   int'(e >= 6));
      check($sformatf("press_busy_e%0d", e),  int'(busy),        int'(e >= 3 && e <= 5));
    end

    // Clean release mirrors the press timing
    set_key(1'b0);
    for (int e = 0; e < 10; e++) begin
      step();
      check($sformatf("rel_pulse_e%0d", e), int'(release_pulse), int'(e == 6));
      check($sformatf("rel_level_e%0d", e), int'(key_level),     int'(e < 6));
      check($sformatf("rel_busy_e%0d", e),  int'(busy),          int'(e >= 3 && e <= 5));
      check($sformatf("rel_nopress_e%0d", e), int'(press_pulse), 0);
    end

    // Bounce and glitch vectors
    for (int v = 0; v < 10; v++) begin
      p0 = n_press;
      r0 = n_rel;
      set_key(tbl[v].pressed);
      idle(tbl[v].hold);
      check($sformatf("vec%0d_press", v),   n_press - p0,     tbl[v].exp_press);
      check($sformatf("vec%0d_release", v), n_rel - r0,       tbl[v].exp_rel);
      check($sformatf("vec%0d_level", v),   int'(key_level),  int'(tbl[v].exp_level));
    end

    // Ten full presses feeding the downstream counter
    idle(4);
    dn_cnt = 4'h0;
    p0 = n_press;
    r0 = n_rel;
    for (int k = 0; k < 10; k++) begin
      set_key(1'b1);
      idle(8);
      set_key(1'b0);
      idle(8);
    end
    check("ten_press_count",   n_press - p0,   10);
    check("ten_release_count", n_rel - r0,     10);
    check("downstream_count",  int'(dn_cnt),   10);
    check("ten_end_level",     int'(key_level), 0);

    // Async reset while qualifying a press
    idle(4);
    set_key(1'b1);
    for (int e = 0; e < 4; e++) step();
    check("pre_reset_busy", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy",  int'(busy),        0);
    check("async_rst_level", int'(key_level),   0);
    check("async_rst_press", int'(press_pulse), 0);
    #1 rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      check($sformatf("post_rst_press_e%0d", e), int'(press_pulse), int'(e == 6));
      check($sformatf("post_rst_level_e%0d", e), int'(key_level),   int'(e >= 6));
    end
    set_key(1'b0);
    idle(10);
    check("post_rst_released", int'(key_level), 0);

`ifdef KEY_REPEAT_EN
    // Auto-repeat: qualification strobe, then +8 and every 4 cycles while held
    set_key(1'b1);
    for (int e = 0; e < 37; e++) begin
      step();
      check($sformatf("rpt_pulse_e%0d", e), int'(press_pulse),
            int'(e == 6 || (e >= 14 && ((e - 14) % 4) == 0)));
    end
    p0 = n_press;
    set_key(1'b0);
    idle(14);
    check("rpt_stop_after_release", n_press - p0, 0);
    check("rpt_released_level", int'(key_level), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
